game_controller_multi: RTL

//  Parametrised sequence-memory game controller. Handles player login, drives the sequence

---
 rtl/game_controller_multi.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/game_controller_multi.sv
// game_controller_multi
//   Sequence-memory game controller. After login it asks the generator for a fresh sequence.
//   Round r shows the first r digits of the sequence RAM, one digit per display interval.
//   It then checks r player entries against the RAM, each entry under the input timer.
//   A game is won after SEQ_LEN rounds. Each restart from a win raises the difficulty,
//   and a loss logs the player out and resets the difficulty.
//
//   Optional feature: define GAMECTRL_BEST_SCORE_EN to track the global best score and its holder.
//
// Ports
//   Clk, Rst                        clock, synchronous active-high reset
//   Passed, PlayerID                login handshake; ID latched when Passed is seen in LOGIN
//   GameStartButton                 start / next-game pulse
//   LoadPlayerIn, PlayerNum         player digit entry strobe and value
//   GoGen / FinGen                  sequence generator request / done
//   SeqAddr / RAMOutput             sequence RAM address / combinational read data
//   TimerReconfig, TimerEnable,
//   TimerTimeout                    per-digit input timer control and expiry
//   TwoSecEnable, TwoSecTimeout     display interval timer control and expiry
//   DispDigit                       registered display digit (all ones = blank)
//   Diff                            registered difficulty level
//   PersonalWin, GlobalWinner       win indicators
//   Logout                          one-cycle pulse on a lost game
module game_controller_multi #(
  parameter int unsigned SEQ_LEN = 4,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DIGIT_W = 4,
  parameter int unsigned ID_W    = 5,
  parameter int unsigned DIFF_W  = 4
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Passed,
  input  logic [ID_W-1:0]    PlayerID,
  input  logic               GameStartButton,
  input  logic               LoadPlayerIn,
  input  logic [DIGIT_W-1:0] PlayerNum,
  output logic               GoGen,
  input  logic               FinGen,
  output logic [ADDR_W-1:0]  SeqAddr,
  input  logic [DIGIT_W-1:0] RAMOutput,
  output logic               TimerReconfig,
  output logic               TimerEnable,
  input  logic               TimerTimeout,
  output logic               TwoSecEnable,
  input  logic               TwoSecTimeout,
  output logic [DIGIT_W-1:0] DispDigit,
  output logic [DIFF_W-1:0]  Diff,
  output logic               PersonalWin,
  output logic               GlobalWinner,
  output logic               Logout
);

  // Round counter needs one bit more than the address so SEQ_LEN == 2**ADDR_W still fits.
  localparam int unsigned RoundW = ADDR_W + 1;
  localparam logic [RoundW-1:0]  RoundOne = RoundW'(1);
  localparam logic [RoundW-1:0]  SeqLenR  = RoundW'(SEQ_LEN);
  localparam logic [ADDR_W-1:0]  IdxOne   = ADDR_W'(1);
  localparam logic [DIGIT_W-1:0] Blank    = {DIGIT_W{1'b1}};
  localparam logic [DIFF_W-1:0]  DiffMax  = {DIFF_W{1'b1}};
  localparam logic [DIFF_W-1:0]  DiffOne  = DIFF_W'(1);

  typedef enum logic [2:0] {
    StLogin,
    StIdle,
    StGen,
    StShow,
    StInput,
    StWin,
    StLose
  } state_e;

  state_e             state_q, state_d;
  logic [RoundW-1:0]  round_q, round_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [DIFF_W-1:0]  diff_q, diff_d;
  logic [DIGIT_W-1:0] disp_q, disp_d;
  logic               reconfig_q, reconfig_d;
  logic               last_digit;

  assign last_digit = ({1'b0, idx_q} == (round_q - RoundOne));

  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    idx_d      = idx_q;
    id_d       = id_q;
    diff_d     = diff_q;
    reconfig_d = 1'b0;
    unique case (state_q)
      StLogin: begin
        if (Passed) begin
          id_d    = PlayerID;
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (GameStartButton) begin
          round_d = RoundOne;
          idx_d   = '0;
          state_d = StGen;
        end
      end
      StGen: begin
        if (FinGen) begin
          idx_d   = '0;
          state_d = StShow;
        end
      end
      StShow: begin
        if (TwoSecTimeout) begin
          if (last_digit) begin
            idx_d      = '0;
            reconfig_d = 1'b1;
            state_d    = StInput;
          end else begin
            idx_d = idx_q + IdxOne;
          end
        end
      end
      StInput: begin
        // An entry in the same cycle as a timeout takes priority over the timeout.
        if (LoadPlayerIn) begin
          if (PlayerNum == RAMOutput) begin
            if (!last_digit) begin
              idx_d      = idx_q + IdxOne;
              reconfig_d = 1'b1;
            end else if (round_q < SeqLenR) begin
              round_d = round_q + RoundOne;
              idx_d   = '0;
              state_d = StShow;
            end else begin
              state_d = StWin;
            end
          end else begin
            state_d = StLose;
          end
        end else if (TimerTimeout) begin
          state_d = StLose;
        end
      end
      StWin: begin
        if (GameStartButton) begin
          if (diff_q != DiffMax) begin
            diff_d = diff_q + DiffOne;
          end
          round_d = RoundOne;
          idx_d   = '0;
          state_d = StGen;
        end
      end
      StLose: begin
        diff_d  = '0;
        state_d = StLogin;
      end
      default: state_d = StLogin;
    endcase
    // Show RAM data only while staying in SHOW so leaving it blanks the display at once.
    disp_d = ((state_q == StShow) && (state_d == StShow)) ? RAMOutput : Blank;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= StLogin;
      round_q    <= RoundOne;
      idx_q      <= '0;
      id_q       <= '0;
      diff_q     <= '0;
      disp_q     <= Blank;
      reconfig_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      round_q    <= round_d;
      idx_q      <= idx_d;
      id_q       <= id_d;
      diff_q     <= diff_d;
      disp_q     <= disp_d;
      reconfig_q <= reconfig_d;
    end
  end

  // Reconfig is registered so its pulse always lands in an INPUT cycle with the timer enabled.
  assign TimerReconfig = reconfig_q;
  assign GoGen         = (state_q == StGen);
  assign TwoSecEnable  = (state_q == StShow);
  assign TimerEnable   = (state_q == StInput);
  assign PersonalWin   = (state_q == StWin);
  assign Logout        = (state_q == StLose);
  assign SeqAddr       = idx_q;
  assign DispDigit     = disp_q;
  assign Diff          = diff_q;

`ifdef GAMECTRL_BEST_SCORE_EN
  localparam int unsigned ScoreW = $clog2(SEQ_LEN + 1);

  logic [ScoreW-1:0] best_q, best_d, score;
  logic [ID_W-1:0]   best_id_q, best_id_d;

  always_comb begin
    best_d    = best_q;
    best_id_d = best_id_q;
    // Completed rounds: all of them on a win, the ones before the current round on a loss.
    score     = (state_d == StWin) ? ScoreW'(SEQ_LEN) : ScoreW'(round_q - RoundOne);
    if ((state_q != state_d) && ((state_d == StWin) || (state_d == StLose)) &&
        (score > best_q)) begin
      best_d    = score;
      best_id_d = id_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      best_q    <= '0;
      best_id_q <= '0;
    end else begin
      best_q    <= best_d;
      best_id_q <= best_id_d;
    end
  end

  assign GlobalWinner = (state_q != StLogin) && (id_q == best_id_q) && (best_q != '0);
`else
  assign GlobalWinner = 1'b0;
`endif

endmodule
